// File: rtl/cs_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 active-low chip-select decoder among 8 requesters.
// Drives the decoder select/enable and mirrors the decoded active-low grant vector on Y.
//
// state   | meaning
// IDLE    | no owner; pick the next requester starting at ptr
// GRANT   | owner idx drives the decoder; count hold cycles
// HOLDOFF | one dead cycle between owners
module cs_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic       G,
    output logic [7:0] Y,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       grant_q, grant_nxt;
    logic [7:0] y_q, y_nxt;
    logic       to_q, to_nxt;
    logic [2:0] pick;
    logic [2:0] cand;
    logic       forced;
    logic       release_now;

    // Descending scan so the candidate closest to ptr wins.
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) pick = cand;
        end
    end

    assign forced      = HOLD_EN && (cnt == HOLD_LAST);
    assign release_now = !req[idx] || forced;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        grant_nxt = grant_q;
        y_nxt     = y_q;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt   = pick;
                    grant_nxt = 1'b1;
                    y_nxt     = ~(8'b1 << pick);
                    cnt_nxt   = 8'd0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_nxt = 1'b0;
                    y_nxt     = 8'hFF;
                    ptr_nxt   = idx + 3'd1;
                    // A release that coincides with req dropping counts as voluntary.
                    to_nxt    = forced && req[idx];
                    state_nxt = HOLDOFF;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            HOLDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            idx     <= 3'd0;
            cnt     <= 8'd0;
            grant_q <= 1'b0;
            y_q     <= 8'hFF;
            to_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            grant_q <= grant_nxt;
            y_q     <= y_nxt;
            to_q    <= to_nxt;
        end
    end

    assign C       = idx[2];
    assign B       = idx[1];
    assign A       = idx[0];
    assign G       = grant_q;
    assign busy    = grant_q;
    assign Y       = y_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// Directed bench for cs_rr_arbiter: one instance with MAX_HOLD=4, one with the timeout disabled.
module tb_cs_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;

    logic       c4, b4, a4, g4, busy4, to4;
    logic [7:0] y4;
    logic       c0, b0, a0, g0, busy0, to0;
    logic [7:0] y0;
    logic [2:0] cba4, cba0;

    int n_cmp = 0;
    int n_err = 0;

    assign cba4 = {c4, b4, a4};
    assign cba0 = {c0, b0, a0};

    cs_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .C(c4), .B(b4), .A(a4), .G(g4), .Y(y4), .busy(busy4), .timeout(to4)
    );

    cs_rr_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req),
        .C(c0), .B(b0), .A(a0), .G(g0), .Y(y0), .busy(busy0), .timeout(to0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req = 8'h00;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Four grant cycles for owner, the release edge, then the dead cycle.
    task automatic serve4(input int owner, input logic exp_to);
        logic [7:0] ey;
        ey = 8'hFF;
        ey[owner] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("serve_y", y4, ey);
            chk("serve_cba", {5'd0, cba4}, 8'(owner));
            chk("serve_g", {7'd0, g4}, 8'd1);
            chk("serve_to", {7'd0, to4}, 8'd0);
        end
        tick();
        chk("rel_y", y4, 8'hFF);
        chk("rel_g", {7'd0, g4}, 8'd0);
        chk("rel_to", {7'd0, to4}, {7'd0, exp_to});
        chk("rel_cba", {5'd0, cba4}, 8'(owner));
        tick();
        chk("hold_y", y4, 8'hFF);
        chk("hold_to", {7'd0, to4}, 8'd0);
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_y4", y4, 8'hFF);
        chk("rst_g4", {7'd0, g4}, 8'd0);
        chk("rst_busy4", {7'd0, busy4}, 8'd0);
        chk("rst_to4", {7'd0, to4}, 8'd0);
        chk("rst_cba4", {5'd0, cba4}, 8'd0);
        chk("rst_y0", y0, 8'hFF);
        rst = 1'b0;

        // Asynchronous reset in the middle of a grant to owner 5
        req = 8'h20;
        tick();
        chk("a_y", y4, 8'hDF);
        chk("a_cba", {5'd0, cba4}, 8'd5);
        chk("a_g", {7'd0, g4}, 8'd1);
        chk("a_busy", {7'd0, busy4}, 8'd1);
        tick();
        chk("a_y2", y4, 8'hDF);
        #3;
        rst = 1'b1;
        #1;
        chk("async_y", y4, 8'hFF);
        chk("async_g", {7'd0, g4}, 8'd0);
        chk("async_busy", {7'd0, busy4}, 8'd0);
        chk("async_cba", {5'd0, cba4}, 8'd0);
        chk("async_y0", y0, 8'hFF);
        #1;
        rst = 1'b0;
        tick();
        chk("after_rst_y", y4, 8'hDF);

        // Single requester 3 for four cycles; dut4 sees req fall in its 4th grant cycle
        do_reset();
        req = 8'h08;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_y0", y0, 8'hF7);
            chk("b_cba0", {5'd0, cba0}, 8'd3);
            chk("b_g0", {7'd0, g0}, 8'd1);
            chk("b_to0", {7'd0, to0}, 8'd0);
            chk("b_y4", y4, 8'hF7);
        end
        req = 8'h00;
        tick();
        chk("b_rel_y0", y0, 8'hFF);
        chk("b_rel_g0", {7'd0, g0}, 8'd0);
        chk("b_rel_busy0", {7'd0, busy0}, 8'd0);
        chk("b_rel_to0", {7'd0, to0}, 8'd0);
        chk("b_rel_cba0", {5'd0, cba0}, 8'd3);
        chk("bnd_y4", y4, 8'hFF);
        chk("bnd_to4", {7'd0, to4}, 8'd0);
        tick();
        chk("b_hold_y0", y0, 8'hFF);
        chk("b_hold_to0", {7'd0, to0}, 8'd0);

        // Round-robin between 0 and 7 with forced releases
        do_reset();
        req = 8'h81;
        for (int p = 0; p < 4; p++) serve4((p % 2 == 0) ? 0 : 7, 1'b1);

        // Rotation: owner 2 releases, then 5, 1, 2 are served
        do_reset();
        req = 8'h04;
        tick();
        chk("d_y2", y4, 8'hFB);
        req = 8'h00;
        tick();
        chk("d_rel", y4, 8'hFF);
        chk("d_rel_to", {7'd0, to4}, 8'd0);
        req = 8'h26;
        tick();
        chk("d_idle", y4, 8'hFF);
        serve4(5, 1'b1);
        serve4(1, 1'b1);
        tick();
        chk("d_y_last", y4, 8'hFB);
        chk("d_cba_last", {5'd0, cba4}, 8'd2);

        // Timeout disabled: grant never released
        do_reset();
        req = 8'h08;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("nohold_y0", y0, 8'hF7);
            chk("nohold_to0", {7'd0, to0}, 8'd0);
        end

        // Random requests with invariant checks on both instances
        do_reset();
        for (int i = 0; i < 200; i++) begin
            req = 8'($urandom);
            tick();
            chk("inv_onehot4", {7'd0, $onehot0(~y4)}, 8'd1);
            chk("inv_gbusy4", {7'd0, g4}, {7'd0, busy4});
            if (g4) chk("inv_dec4", y4, ~(8'b1 << cba4));
            else    chk("inv_idle4", y4, 8'hFF);
            chk("inv_onehot0", {7'd0, $onehot0(~y0)}, 8'd1);
            chk("inv_gbusy0", {7'd0, g0}, {7'd0, busy0});
            if (g0) chk("inv_dec0", y0, ~(8'b1 << cba0));
            else    chk("inv_idle0", y0, 8'hFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cs_rr_arbiter.md
Name: cs_rr_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 active-low chip-select decoder among 8 requesters.
- Drives the decoder's select inputs (C,B,A) and high enable G, and mirrors the decoded active-low grant vector so downstream logic needs no separate decoder.
- Guarantees at most one grant at a time, a dead cycle between owners, and an optional hold timeout.
- Sits between requesting peripherals and the shared chip-select decoder.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold a grant. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i]=1 means requester i wants the resource. Level-sensitive.
- C  output  1  decoder select MSB (owner index bit 2).
- B  output  1  decoder select bit 1.
- A  output  1  decoder select LSB.
- G  output  1  decoder enable, active high; 1 only in GRANT.
- Y  output  8  active-low one-hot grant; Y[i]=0 iff requester i owns the resource.
- busy  output  1  1 while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- One clock, reset is asynchronous and active-high; all state and outputs are registered.
- Reset values: state=IDLE, ptr=0, cnt=0, {C,B,A}=3'b000, G=0, Y=8'hFF, busy=0, timeout=0. Reset mid-grant drops the grant immediately (asynchronous).
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select idx = first i with req[i]=1, searching ptr, ptr+1, … mod 8.
  - At the same edge: {C,B,A}<=idx, G<=1, Y<=~(8'b1<<idx), busy<=1, cnt<=0, and go to GRANT.
  - Latency: req high before edge N gives Y[idx]=0 after edge N.
- State GRANT:
  - Outputs hold. cnt increments each cycle and saturates at 255.
  - Release when req[idx]==0, or when MAX_HOLD!=0 and cnt==MAX_HOLD-1.
  - On release, at the edge: G<=0, Y<=8'hFF, busy<=0, ptr<=(idx+1) mod 8, go to HOLDOFF.
  - {C,B,A} keep their last value.
  - timeout<=1 only if the release was forced while req[idx] was still 1.
  - Grant duration: a requester holding req continuously owns the resource exactly MAX_HOLD cycles.
  - If req[idx] falls in the same cycle the timeout count is reached, the release is voluntary and timeout=0.
- State HOLDOFF:
  - Lasts exactly 1 cycle with all grants deasserted. timeout returns to 0. Then go to IDLE.
  - Requests present during HOLDOFF are evaluated in IDLE on the following edge, so the minimum gap between grants is 2 idle cycles at Y.
- Fairness:
  - ptr advances past each owner, so a continuously requesting i waits at most 7 other grants.
  - A timed-out requester still holding req is served again only after all other pending requesters.
- Invariants:
  - Y is 8'hFF or exactly one zero bit.
  - G==busy.
  - Whenever G=1: Y == ~(1<<{C,B,A}).
- Requests for other indices during GRANT are ignored until IDLE. Requests are not latched: a pulse entirely within GRANT/HOLDOFF is lost.

Test Plan:
- Reset: assert rst mid-GRANT (owner 5) -> Y=8'hFF, G=0, busy=0, {C,B,A}=0 immediately, without waiting for a clock edge; after release, req=8'h20 -> Y=8'hDF one edge later.
- Single requester: req=8'h08 for 4 cycles then 0 -> Y=8'hF7, {C,B,A}=3, G=1 for 4 cycles; Y=8'hFF in HOLDOFF; timeout stays 0.
- Round-robin: req=8'h81 held, MAX_HOLD=4 -> owners 0,7,0,7…; each grant 4 cycles; timeout pulses after each; 2-cycle gaps between grants.
- Rotation: ptr=3 after owner 2 releases, req=8'h26 -> owner 5, then 1, then 2.
- Timeout boundary: MAX_HOLD=4, req[3] falls in 4th grant cycle -> release with timeout=0; MAX_HOLD=0 with req held 300 cycles -> grant never released.
- Invariant checker throughout a randomized req run: at most one Y bit low, and G==busy every cycle.
